// File: rtl/id_stage_pkg.sv
// Shared decode definitions: opcode/funct constants, instruction IDs and
// immediate/register-use helpers for the ID stage.
package id_stage_pkg;

    localparam int InstIDDepth = 8;

    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_COMPU    = 7'b0010011;
    localparam logic [6:0] OPCODE_COMPR    = 7'b0110011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FUNCT3_000 = 3'b000;
    localparam logic [2:0] FUNCT3_001 = 3'b001;
    localparam logic [2:0] FUNCT3_010 = 3'b010;
    localparam logic [2:0] FUNCT3_011 = 3'b011;
    localparam logic [2:0] FUNCT3_100 = 3'b100;
    localparam logic [2:0] FUNCT3_101 = 3'b101;
    localparam logic [2:0] FUNCT3_110 = 3'b110;
    localparam logic [2:0] FUNCT3_111 = 3'b111;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef logic [InstIDDepth-1:0] id_t;

    localparam id_t ID_ILLEGAL = 8'd0;
    localparam id_t ID_LUI     = 8'd1;
    localparam id_t ID_AUIPC   = 8'd2;
    localparam id_t ID_JAL     = 8'd3;
    localparam id_t ID_JALR    = 8'd4;
    localparam id_t ID_BEQ     = 8'd5;
    localparam id_t ID_BNE     = 8'd6;
    localparam id_t ID_BLT     = 8'd7;
    localparam id_t ID_BGE     = 8'd8;
    localparam id_t ID_BLTU    = 8'd9;
    localparam id_t ID_BGEU    = 8'd10;
    localparam id_t ID_LB      = 8'd11;
    localparam id_t ID_LH      = 8'd12;
    localparam id_t ID_LW      = 8'd13;
    localparam id_t ID_LBU     = 8'd14;
    localparam id_t ID_LHU     = 8'd15;
    localparam id_t ID_SB      = 8'd16;
    localparam id_t ID_SH      = 8'd17;
    localparam id_t ID_SW      = 8'd18;
    localparam id_t ID_ADDI    = 8'd19;
    localparam id_t ID_SLTI    = 8'd20;
    localparam id_t ID_SLTIU   = 8'd21;
    localparam id_t ID_XORI    = 8'd22;
    localparam id_t ID_ORI     = 8'd23;
    localparam id_t ID_ANDI    = 8'd24;
    localparam id_t ID_SLLI    = 8'd25;
    localparam id_t ID_SRLI    = 8'd26;
    localparam id_t ID_SRAI    = 8'd27;
    localparam id_t ID_ADD     = 8'd28;
    localparam id_t ID_SUB     = 8'd29;
    localparam id_t ID_SLL     = 8'd30;
    localparam id_t ID_SLT     = 8'd31;
    localparam id_t ID_SLTU    = 8'd32;
    localparam id_t ID_XOR     = 8'd33;
    localparam id_t ID_SRL     = 8'd34;
    localparam id_t ID_SRA     = 8'd35;
    localparam id_t ID_OR      = 8'd36;
    localparam id_t ID_AND     = 8'd37;
    localparam id_t ID_FENCE   = 8'd38;
    localparam id_t ID_ECALL   = 8'd39;
    localparam id_t ID_EBREAK  = 8'd40;
    localparam id_t ID_MUL     = 8'd41;
    localparam id_t ID_MULH    = 8'd42;
    localparam id_t ID_MULHSU  = 8'd43;
    localparam id_t ID_MULHU   = 8'd44;
    localparam id_t ID_DIV     = 8'd45;
    localparam id_t ID_DIVU    = 8'd46;
    localparam id_t ID_REM     = 8'd47;
    localparam id_t ID_REMU    = 8'd48;

    // FMT_SH is the I-format shift variant whose immediate is the bare shamt.
    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    function automatic logic [31:0] imm_of(input fmt_e fmt, input logic [31:0] inst);
        logic [31:0] r;
        case (fmt)
            FMT_I:   r = {{20{inst[31]}}, inst[31:20]};
            FMT_SH:  r = {27'd0, inst[24:20]};
            FMT_S:   r = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   r = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   r = {inst[31:12], 12'd0};
            FMT_J:   r = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Returns {rs1_vld, rs2_vld, rd_vld}.
    function automatic logic [2:0] vld_of(input fmt_e fmt);
        logic [2:0] r;
        case (fmt)
            FMT_R:          r = 3'b111;
            FMT_I, FMT_SH:  r = 3'b101;
            FMT_S, FMT_B:   r = 3'b110;
            FMT_U, FMT_J:   r = 3'b001;
            default:        r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_decode_comb.sv
// Purely combinational RV32I(+M) decoder: instruction word in, fields,
// sign-extended immediate, instruction ID and illegal flag out.
module id_decode_comb
    import id_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int INST_ID_W = InstIDDepth,
    parameter int EN_M      = 0
) (
    input  logic [31:0]          inst,
    output logic [6:0]           opcode,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic                 rs1_vld,
    output logic                 rs2_vld,
    output logic                 rd_vld,
    output logic [XLEN-1:0]      imm,
    output logic [INST_ID_W-1:0] inst_id,
    output logic                 illegal
);

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    id_t         id;
    fmt_e        fmt;
    logic [2:0]  vld;
    logic [31:0] imm32;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    always_comb begin
        id  = ID_ILLEGAL;
        fmt = FMT_NONE;
        case (opcode)
            OPCODE_LUI:   begin id = ID_LUI;   fmt = FMT_U; end
            OPCODE_AUIPC: begin id = ID_AUIPC; fmt = FMT_U; end
            OPCODE_JAL:   begin id = ID_JAL;   fmt = FMT_J; end
            OPCODE_JALR: begin
                fmt = FMT_I;
                if (funct3 == FUNCT3_000) id = ID_JALR;
            end
            OPCODE_BRANCH: begin
                fmt = FMT_B;
                case (funct3)
                    FUNCT3_000: id = ID_BEQ;
                    FUNCT3_001: id = ID_BNE;
                    FUNCT3_100: id = ID_BLT;
                    FUNCT3_101: id = ID_BGE;
                    FUNCT3_110: id = ID_BLTU;
                    FUNCT3_111: id = ID_BGEU;
                    default:    id = ID_ILLEGAL;
                endcase
            end
            OPCODE_LOAD: begin
                fmt = FMT_I;
                case (funct3)
                    FUNCT3_000: id = ID_LB;
                    FUNCT3_001: id = ID_LH;
                    FUNCT3_010: id = ID_LW;
                    FUNCT3_100: id = ID_LBU;
                    FUNCT3_101: id = ID_LHU;
                    default:    id = ID_ILLEGAL;
                endcase
            end
            OPCODE_STORE: begin
                fmt = FMT_S;
                case (funct3)
                    FUNCT3_000: id = ID_SB;
                    FUNCT3_001: id = ID_SH;
                    FUNCT3_010: id = ID_SW;
                    default:    id = ID_ILLEGAL;
                endcase
            end
            OPCODE_COMPU: begin
                fmt = FMT_I;
                case (funct3)
                    FUNCT3_000: id = ID_ADDI;
                    FUNCT3_010: id = ID_SLTI;
                    FUNCT3_011: id = ID_SLTIU;
                    FUNCT3_100: id = ID_XORI;
                    FUNCT3_110: id = ID_ORI;
                    FUNCT3_111: id = ID_ANDI;
                    FUNCT3_001: begin
                        fmt = FMT_SH;
                        if (funct7 == FUNCT7_BASE) id = ID_SLLI;
                    end
                    default: begin
                        fmt = FMT_SH;
                        if (funct7 == FUNCT7_BASE)     id = ID_SRLI;
                        else if (funct7 == FUNCT7_ALT) id = ID_SRAI;
                    end
                endcase
            end
            OPCODE_COMPR: begin
                fmt = FMT_R;
                if (funct7 == FUNCT7_BASE) begin
                    case (funct3)
                        FUNCT3_000: id = ID_ADD;
                        FUNCT3_001: id = ID_SLL;
                        FUNCT3_010: id = ID_SLT;
                        FUNCT3_011: id = ID_SLTU;
                        FUNCT3_100: id = ID_XOR;
                        FUNCT3_101: id = ID_SRL;
                        FUNCT3_110: id = ID_OR;
                        default:    id = ID_AND;
                    endcase
                end else if (funct7 == FUNCT7_ALT) begin
                    if (funct3 == FUNCT3_000)      id = ID_SUB;
                    else if (funct3 == FUNCT3_101) id = ID_SRA;
                end else if (funct7 == FUNCT7_MULDIV && EN_M != 0) begin
                    case (funct3)
                        FUNCT3_000: id = ID_MUL;
                        FUNCT3_001: id = ID_MULH;
                        FUNCT3_010: id = ID_MULHSU;
                        FUNCT3_011: id = ID_MULHU;
                        FUNCT3_100: id = ID_DIV;
                        FUNCT3_101: id = ID_DIVU;
                        FUNCT3_110: id = ID_REM;
                        default:    id = ID_REMU;
                    endcase
                end
            end
            OPCODE_MISC_MEM: begin
                fmt = FMT_I;
                if (funct3 == FUNCT3_000) id = ID_FENCE;
            end
            OPCODE_SYSTEM: begin
                fmt = FMT_I;
                if (funct3 == FUNCT3_000 && rs1 == 5'd0 && rd == 5'd0) begin
                    if (inst[31:20] == 12'd0)      id = ID_ECALL;
                    else if (inst[31:20] == 12'd1) id = ID_EBREAK;
                end
            end
            default: id = ID_ILLEGAL;
        endcase
    end

    // Illegal encodings and R-type carry no immediate; both report zero.
    always_comb begin
        illegal = (id == ID_ILLEGAL);
        vld     = illegal ? 3'b000 : vld_of(fmt);
        imm32   = illegal ? 32'd0 : imm_of(fmt, inst);
        rs1_vld = vld[2];
        rs2_vld = vld[1];
        rd_vld  = vld[0] && (rd != 5'd0);
        imm     = XLEN'($signed(imm32));
        inst_id = INST_ID_W'(id);
    end

endmodule

// File: rtl/id_stage.sv
// Registered decode stage between IF and EX: output register with
// valid/ready handshake, load-use bubbles, JAL redirect and EX flush.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int INST_ID_W   = InstIDDepth,
    parameter int EN_M        = 0,
    parameter int EN_LOAD_USE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [XLEN-1:0]      in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [6:0]           out_opcode,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd,
    output logic                 out_rs1_vld,
    output logic                 out_rs2_vld,
    output logic                 out_rd_vld,
    output logic [XLEN-1:0]      out_imm,
    output logic [INST_ID_W-1:0] out_inst_id,
    output logic                 out_illegal,
    output logic                 jmp_vld,
    output logic [XLEN-1:0]      jmp_addr
);

    logic [6:0]           dec_opcode;
    logic [4:0]           dec_rs1;
    logic [4:0]           dec_rs2;
    logic [4:0]           dec_rd;
    logic                 dec_rs1_vld;
    logic                 dec_rs2_vld;
    logic                 dec_rd_vld;
    logic [XLEN-1:0]      dec_imm;
    logic [INST_ID_W-1:0] dec_inst_id;
    logic                 dec_illegal;

    logic held_load;
    logic hazard;
    logic stall;
    logic take;

    id_decode_comb #(
        .XLEN      (XLEN),
        .INST_ID_W (INST_ID_W),
        .EN_M      (EN_M)
    ) u_decode (
        .inst    (in_inst),
        .opcode  (dec_opcode),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .rs1_vld (dec_rs1_vld),
        .rs2_vld (dec_rs2_vld),
        .rd_vld  (dec_rd_vld),
        .imm     (dec_imm),
        .inst_id (dec_inst_id),
        .illegal (dec_illegal)
    );

    // Handshake: a transfer happens on a cycle where valid && ready are both
    // high; valid never waits on ready, and a held output stays unchanged
    // until it transfers. Inputs taken during a flush or during the JAL
    // redirect cycle are accepted (IF is being redirected) but discarded.
    assign held_load = out_valid && (out_opcode == OPCODE_LOAD) && out_rd_vld;
    assign hazard    = in_valid &&
                       ((dec_rs1_vld && dec_rs1 == out_rd) ||
                        (dec_rs2_vld && dec_rs2 == out_rd));
    assign stall     = (EN_LOAD_USE != 0) && held_load && hazard && !flush && !jmp_vld;
    assign in_ready  = flush || jmp_vld || ((!out_valid || out_ready) && !stall);
    assign take      = in_valid && in_ready && !flush && !jmp_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_opcode  <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_rs1_vld <= 1'b0;
            out_rs2_vld <= 1'b0;
            out_rd_vld  <= 1'b0;
            out_imm     <= '0;
            out_inst_id <= '0;
            out_illegal <= 1'b0;
            jmp_vld     <= 1'b0;
            jmp_addr    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            jmp_vld   <= 1'b0;
        end else begin
            jmp_vld <= 1'b0;
            if (take) begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_opcode  <= dec_opcode;
                out_rs1     <= dec_rs1;
                out_rs2     <= dec_rs2;
                out_rd      <= dec_rd;
                out_rs1_vld <= dec_rs1_vld;
                out_rs2_vld <= dec_rs2_vld;
                out_rd_vld  <= dec_rd_vld;
                out_imm     <= dec_imm;
                out_inst_id <= dec_inst_id;
                out_illegal <= dec_illegal;
                jmp_vld     <= (dec_opcode == OPCODE_JAL) && !dec_illegal;
                jmp_addr    <= in_pc + dec_imm;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
